// File: rtl/uart_bus_pkg.sv
// Shared definitions for the UART host-side register block:
//   register addresses, STATUS bit positions and the bus FSM state encoding.
package uart_bus_pkg;

  localparam logic [2:0] ADDR_CTRL1  = 3'd0;
  localparam logic [2:0] ADDR_CTRL2  = 3'd1;
  localparam logic [2:0] ADDR_CTRL3  = 3'd2;
  localparam logic [2:0] ADDR_APPLY  = 3'd3;
  localparam logic [2:0] ADDR_TXDATA = 3'd4;
  localparam logic [2:0] ADDR_RXDATA = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;
  localparam logic [2:0] ADDR_PARERR = 3'd7;

  localparam int unsigned STAT_EMPTY  = 0;
  localparam int unsigned STAT_FULL   = 1;
  localparam int unsigned STAT_TX_OVR = 2;
  localparam int unsigned STAT_RX_UDR = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_STB  = 2'd1,
    S_RD_WAIT = 2'd2,
    S_ACK     = 2'd3
  } bus_state_e;

endpackage

// File: rtl/uart_bus_regs_if.sv
// Host bus between a bus master and uart_bus_regs.
//   bus_cs_i    access request, access starts on its rising edge
//   bus_we_i    1 = write, 0 = read
//   bus_addr_i  register address
//   bus_wdata_i write data
//   bus_rdata_o read data, valid only with bus_ack_o
//   bus_ack_o   one-cycle completion pulse
interface uart_bus_regs_if;
  logic       bus_cs_i;
  logic       bus_we_i;
  logic [2:0] bus_addr_i;
  logic [7:0] bus_wdata_i;
  logic [7:0] bus_rdata_o;
  logic       bus_ack_o;

  modport master (
    output bus_cs_i, bus_we_i, bus_addr_i, bus_wdata_i,
    input  bus_rdata_o, bus_ack_o
  );

  modport slave (
    input  bus_cs_i, bus_we_i, bus_addr_i, bus_wdata_i,
    output bus_rdata_o, bus_ack_o
  );
endinterface

// File: rtl/uart_bus_regs.sv
// Byte-wide bus slave in front of the UART core.
//   clk, rst          system clock, asynchronous active-low reset
//   bus               host bus (slave modport)
//   p_We_o            one-cycle parameter-apply pulse to the core
//   CtrlReg1..3_o     control registers to the core
//   data_o, n_we_o    TX FIFO write data / active-low write strobe
//   p_full_i          TX FIFO full
//   data_i, n_rd_o    RX FIFO data / active-low read strobe
//   p_empty_i         RX FIFO empty
//   ParityErrorNum_i  parity error count, readable at PARERR
module uart_bus_regs
  import uart_bus_pkg::*;
#(
  parameter int unsigned RD_LAT     = 1,
  parameter logic [7:0]  CTRL1_RST  = 8'h00,
  parameter logic [7:0]  CTRL2_RST  = 8'h00,
  parameter logic [7:0]  CTRL3_RST  = 8'h00,
  parameter bit          AUTO_APPLY = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  uart_bus_regs_if.slave   bus,
  output logic             p_We_o,
  output logic [7:0]       CtrlReg1_o,
  output logic [7:0]       CtrlReg2_o,
  output logic [7:0]       CtrlReg3_o,
  output logic [7:0]       data_o,
  output logic             n_we_o,
  input  logic             p_full_i,
  input  logic [7:0]       data_i,
  output logic             n_rd_o,
  input  logic             p_empty_i,
  input  logic [7:0]       ParityErrorNum_i
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  bus_state_e state_q, state_d;
  logic       cs_q;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] ctrl1_q, ctrl1_d, ctrl2_q, ctrl2_d, ctrl3_q, ctrl3_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rdata_q, rdata_d;
  logic       n_we_q, n_we_d;
  logic       p_we_q, p_we_d;
  logic       tx_ovr_q, tx_ovr_d;
  logic       rx_udr_q, rx_udr_d;
  logic       apply_pend_q;
  logic       access;
  logic [7:0] status;

  assign access = bus.bus_cs_i & ~cs_q;

  always_comb begin
    status              = '0;
    status[STAT_EMPTY]  = p_empty_i;
    status[STAT_FULL]   = p_full_i;
    status[STAT_TX_OVR] = tx_ovr_q;
    status[STAT_RX_UDR] = rx_udr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cs_q         <= 1'b0;
      cnt_q        <= '0;
      ctrl1_q      <= CTRL1_RST;
      ctrl2_q      <= CTRL2_RST;
      ctrl3_q      <= CTRL3_RST;
      data_q       <= '0;
      rdata_q      <= '0;
      n_we_q       <= 1'b1;
      p_we_q       <= 1'b0;
      tx_ovr_q     <= 1'b0;
      rx_udr_q     <= 1'b0;
      apply_pend_q <= AUTO_APPLY;
    end else begin
      state_q      <= state_d;
      cs_q         <= bus.bus_cs_i;
      cnt_q        <= cnt_d;
      ctrl1_q      <= ctrl1_d;
      ctrl2_q      <= ctrl2_d;
      ctrl3_q      <= ctrl3_d;
      data_q       <= data_d;
      rdata_q      <= rdata_d;
      n_we_q       <= n_we_d;
      p_we_q       <= p_we_d;
      tx_ovr_q     <= tx_ovr_d;
      rx_udr_q     <= rx_udr_d;
      apply_pend_q <= 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl1_d  = ctrl1_q;
    ctrl2_d  = ctrl2_q;
    ctrl3_d  = ctrl3_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    n_we_d   = 1'b1;
    // The post-reset apply pulse is issued from the first clock edge.
    p_we_d   = apply_pend_q;
    tx_ovr_d = tx_ovr_q;
    rx_udr_d = rx_udr_q;

    case (state_q)
      S_IDLE: begin
        if (access) begin
          state_d = S_ACK;
          rdata_d = '0;
          if (bus.bus_we_i) begin
            case (bus.bus_addr_i)
              ADDR_CTRL1:  ctrl1_d = bus.bus_wdata_i;
              ADDR_CTRL2:  ctrl2_d = bus.bus_wdata_i;
              ADDR_CTRL3:  ctrl3_d = bus.bus_wdata_i;
              // An apply pulse already on the wire covers this request,
              // so the two merge into a single one-cycle pulse.
              ADDR_APPLY:  if (!p_we_q) p_we_d = 1'b1;
              ADDR_TXDATA: begin
                if (!p_full_i) begin
                  n_we_d = 1'b0;
                  data_d = bus.bus_wdata_i;
                end else begin
                  tx_ovr_d = 1'b1;
                end
              end
              default: ;
            endcase
          end else begin
            case (bus.bus_addr_i)
              ADDR_CTRL1:  rdata_d = ctrl1_q;
              ADDR_CTRL2:  rdata_d = ctrl2_q;
              ADDR_CTRL3:  rdata_d = ctrl3_q;
              ADDR_RXDATA: begin
                if (!p_empty_i) state_d = S_RD_STB;
                else            rx_udr_d = 1'b1;
              end
              ADDR_STATUS: begin
                rdata_d  = status;
                tx_ovr_d = 1'b0;
                rx_udr_d = 1'b0;
              end
              ADDR_PARERR: rdata_d = ParityErrorNum_i;
              default: ;
            endcase
          end
        end
      end
      S_RD_STB: begin
        state_d = S_RD_WAIT;
        cnt_d   = '0;
      end
      S_RD_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          rdata_d = data_i;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.bus_ack_o   = (state_q == S_ACK);
  assign bus.bus_rdata_o = rdata_q;
  assign n_rd_o          = (state_q != S_RD_STB);
  assign n_we_o          = n_we_q;
  assign p_We_o          = p_we_q;
  assign data_o          = data_q;
  assign CtrlReg1_o      = ctrl1_q;
  assign CtrlReg2_o      = ctrl2_q;
  assign CtrlReg3_o      = ctrl3_q;

endmodule

// File: tb/tb_uart_bus_regs.sv
// Self-checking bench for uart_bus_regs with a scoreboard of expected acks.
module tb_uart_bus_regs;
  import uart_bus_pkg::*;

  localparam int unsigned LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       p_We_o, n_we_o, n_rd_o;
  logic [7:0] CtrlReg1_o, CtrlReg2_o, CtrlReg3_o, data_o, data_i;
  logic       p_full_i = 1'b0;
  logic       p_empty_i = 1'b0;
  logic [7:0] ParityErrorNum_i = 8'h00;

  uart_bus_regs_if bus();

  uart_bus_regs #(
    .RD_LAT(LAT), .CTRL1_RST(8'h81), .CTRL2_RST(8'h23),
    .CTRL3_RST(8'h45), .AUTO_APPLY(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .p_We_o(p_We_o), .CtrlReg1_o(CtrlReg1_o), .CtrlReg2_o(CtrlReg2_o),
    .CtrlReg3_o(CtrlReg3_o), .data_o(data_o), .n_we_o(n_we_o),
    .p_full_i(p_full_i), .data_i(data_i), .n_rd_o(n_rd_o),
    .p_empty_i(p_empty_i), .ParityErrorNum_i(ParityErrorNum_i)
  );

  always #5 clk = ~clk;

  // RX FIFO model: data valid exactly LAT cycles after the read strobe.
  logic [1:0] rd_pipe = '0;
  always @(posedge clk) rd_pipe <= {rd_pipe[0], ~n_rd_o};
  assign data_i = rd_pipe[LAT-1] ? 8'hA7 : 8'h00;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] rdata;
    int         ack_cyc;
    bit         is_rd;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0, n_fail = 0;
  int acks = 0, last_ack_cyc = 0;
  int pwe_hi = 0, pwe_cyc = 0, nwe_lo = 0, nwe_cyc = 0, nrd_lo = 0, nrd_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle monitor: pops the scoreboard on each ack, tracks strobes.
  always @(negedge clk) begin
    exp_t e;
    if (bus.bus_ack_o) begin
      acks++;
      last_ack_cyc = cyc;
      if (sb.size() == 0) begin
        check_eq("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("ack_cycle", cyc, e.ack_cyc);
        if (e.is_rd) check_eq("rdata", {24'd0, bus.bus_rdata_o}, {24'd0, e.rdata});
      end
    end
    if (p_We_o)  begin pwe_hi++; pwe_cyc = cyc; end
    if (!n_we_o) begin nwe_lo++; nwe_cyc = cyc; end
    if (!n_rd_o) begin nrd_lo++; nrd_cyc = cyc; end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic bus_access(input bit we, input logic [2:0] addr, input logic [7:0] wdata,
                            input logic [7:0] exp_rd, input int lat);
    exp_t e;
    int   a0;
    tick();
    bus.bus_cs_i    = 1'b1;
    bus.bus_we_i    = we;
    bus.bus_addr_i  = addr;
    bus.bus_wdata_i = wdata;
    e.rdata   = exp_rd;
    e.is_rd   = !we;
    e.ack_cyc = cyc + lat;
    sb.push_back(e);
    a0 = acks;
    for (int i = 0; i < 20 && acks == a0; i++) tick();
    if (acks == a0) begin
      check_eq("ack_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    bus.bus_cs_i = 1'b0;
  endtask

  typedef struct {
    bit         we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  initial begin
    int   rel, p0, n0, r0, a0;
    exp_t e;
    vec_t vecs[$];

    bus.bus_cs_i = 1'b0; bus.bus_we_i = 1'b0;
    bus.bus_addr_i = '0; bus.bus_wdata_i = '0;

    // Reset values
    repeat (3) tick();
    check_eq("rst_ctrl1", {24'd0, CtrlReg1_o}, 32'h81);
    check_eq("rst_ctrl2", {24'd0, CtrlReg2_o}, 32'h23);
    check_eq("rst_ctrl3", {24'd0, CtrlReg3_o}, 32'h45);
    check_eq("rst_outs", {n_we_o, n_rd_o, p_We_o, bus.bus_ack_o}, 4'b1100);
    check_eq("rst_data", {data_o, bus.bus_rdata_o}, 16'h0000);

    // Auto apply after release
    rel = cyc;
    rst = 1'b1;
    repeat (4) tick();
    check_eq("auto_apply_width", pwe_hi, 1);
    check_eq("auto_apply_cycle", pwe_cyc, rel + 1);

    // CTRL2 write then APPLY
    bus_access(1'b1, ADDR_CTRL2, 8'h9C, 8'h00, 1);
    check_eq("ctrl2_at_ack", {24'd0, CtrlReg2_o}, 32'h9C);
    p0 = pwe_hi;
    bus_access(1'b1, ADDR_APPLY, 8'h55, 8'h00, 1);
    tick();
    check_eq("apply_width", pwe_hi, p0 + 1);
    check_eq("apply_cycle", pwe_cyc, last_ack_cyc);

    // TXDATA write, not full then full
    n0 = nwe_lo;
    bus_access(1'b1, ADDR_TXDATA, 8'h5A, 8'h00, 1);
    tick();
    check_eq("tx_strobe_width", nwe_lo, n0 + 1);
    check_eq("tx_strobe_cycle", nwe_cyc, last_ack_cyc);
    check_eq("tx_data", {24'd0, data_o}, 32'h5A);
    p_full_i = 1'b1;
    bus_access(1'b1, ADDR_TXDATA, 8'h33, 8'h00, 1);
    tick();
    check_eq("tx_full_no_strobe", nwe_lo, n0 + 1);
    bus_access(1'b0, ADDR_STATUS, 8'h00, 8'h06, 1);
    bus_access(1'b0, ADDR_STATUS, 8'h00, 8'h02, 1);
    p_full_i = 1'b0;

    // RXDATA read with latency
    r0 = nrd_lo;
    bus_access(1'b0, ADDR_RXDATA, 8'h00, 8'hA7, LAT + 2);
    tick();
    check_eq("rx_strobe_width", nrd_lo, r0 + 1);
    check_eq("rx_strobe_cycle", nrd_cyc, last_ack_cyc - 3);

    // RXDATA read while empty
    p_empty_i = 1'b1;
    bus_access(1'b0, ADDR_RXDATA, 8'h00, 8'h00, 1);
    tick();
    check_eq("rx_empty_no_strobe", nrd_lo, r0 + 1);
    bus_access(1'b0, ADDR_STATUS, 8'h00, 8'h09, 1);
    p_empty_i = 1'b0;

    // Register map sweep, including no-effect accesses
    ParityErrorNum_i = 8'h3C;
    vecs.push_back('{1'b0, ADDR_CTRL1,  8'h00, 8'h81});
    vecs.push_back('{1'b0, ADDR_CTRL3,  8'h00, 8'h45});
    vecs.push_back('{1'b0, ADDR_APPLY,  8'h00, 8'h00});
    vecs.push_back('{1'b0, ADDR_TXDATA, 8'h00, 8'h00});
    vecs.push_back('{1'b1, ADDR_STATUS, 8'hFF, 8'h00});
    vecs.push_back('{1'b1, ADDR_RXDATA, 8'h77, 8'h00});
    vecs.push_back('{1'b0, ADDR_STATUS, 8'h00, 8'h00});
    vecs.push_back('{1'b1, ADDR_CTRL1,  8'hE1, 8'h00});
    vecs.push_back('{1'b0, ADDR_CTRL1,  8'h00, 8'hE1});
    vecs.push_back('{1'b0, ADDR_PARERR, 8'h00, 8'h3C});
    n0 = nwe_lo;
    r0 = nrd_lo;
    foreach (vecs[i]) bus_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 1);
    tick();
    check_eq("sweep_no_tx_strobe", nwe_lo, n0);
    check_eq("sweep_no_rx_strobe", nrd_lo, r0);

    // Reset during RD_WAIT drops the access
    tick();
    bus.bus_cs_i = 1'b1; bus.bus_we_i = 1'b0; bus.bus_addr_i = ADDR_RXDATA;
    a0 = acks;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_mid_nrd", {31'd0, n_rd_o}, 32'd1);
    check_eq("rst_mid_ack", {31'd0, bus.bus_ack_o}, 32'd0);
    check_eq("rst_mid_ctrl2", {24'd0, CtrlReg2_o}, 32'h23);
    bus.bus_cs_i = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (6) tick();
    check_eq("dropped_access", acks, a0);

    ParityErrorNum_i = 8'h11;
    bus_access(1'b0, ADDR_PARERR, 8'h00, 8'h11, 1);

    // cs held high across reset release: APPLY merges with the auto pulse
    rst = 1'b0;
    tick();
    bus.bus_cs_i = 1'b1; bus.bus_we_i = 1'b1;
    bus.bus_addr_i = ADDR_APPLY; bus.bus_wdata_i = 8'h01;
    tick();
    p0 = pwe_hi;
    a0 = acks;
    rel = cyc;
    e.rdata = 8'h00; e.is_rd = 1'b0; e.ack_cyc = rel + 1;
    sb.push_back(e);
    rst = 1'b1;
    for (int i = 0; i < 20 && acks == a0; i++) tick();
    if (acks == a0) begin
      check_eq("release_ack_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    bus.bus_cs_i = 1'b0;
    repeat (3) tick();
    check_eq("merged_apply_width", pwe_hi, p0 + 1);
    check_eq("merged_apply_cycle", pwe_cyc, rel + 1);

    bus_access(1'b0, ADDR_CTRL2, 8'h00, 8'h23, 1);
    repeat (2) tick();
    check_eq("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/uart_bus_regs.md
# uart_bus_regs

Byte-wide bus slave that sits directly upstream of the UART core and is its only host-side driver. It holds the three control registers and issues the parameter-apply pulse. It turns bus writes into active-low TX FIFO write strobes, and bus reads into active-low RX FIFO read strobes with latency-compensated data capture. It also exposes FIFO status, sticky error flags and the parity error count as readable registers.

## Interface
- RD_LAT, 1, cycles from the RX FIFO read strobe to valid FIFO data (1..4)
- CTRL1_RST, 8'h00, reset value of CTRL1
- CTRL2_RST, 8'h00, reset value of CTRL2
- CTRL3_RST, 8'h00, reset value of CTRL3
- AUTO_APPLY, 1, when 1, issue one p_We_o pulse after reset release
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- bus_cs_i  in  1  access request; an access starts on the rising edge
- bus_we_i  in  1  1 = write, 0 = read; sampled with the cs edge
- bus_addr_i  in  3  register address
- bus_wdata_i  in  8  write data
- bus_rdata_o  out  8  read data; valid only while bus_ack_o = 1
- bus_ack_o  out  1  one-cycle completion pulse
- p_We_o, CtrlReg1_o, CtrlReg2_o, CtrlReg3_o  out  1/8/8/8  to the core's control inputs
- data_o, n_we_o  out  8/1  TX FIFO write data and active-low write strobe
- p_full_i  in  1  TX FIFO full
- data_i, n_rd_o  in/out  8/1  RX FIFO data and active-low read strobe
- p_empty_i  in  1  RX FIFO empty
- ParityErrorNum_i  in  8  parity error count from the core

## Operation
- Register map:
  - 0 CTRL1 (R/W)
  - 1 CTRL2 (R/W)
  - 2 CTRL3 (R/W)
  - 3 APPLY: write of any value pulses p_We_o; reads 0
  - 4 TXDATA: write only; reads 0
  - 5 RXDATA: read only
  - 6 STATUS (R): bit0 p_empty_i, bit1 p_full_i, bit2 tx_ovr, bit3 rx_udr; bits 7..4 read 0
  - 7 PARERR (R): ParityErrorNum_i
- Writes to read-only registers and reads of write-only registers are acked with no side effect; a read of a write-only register returns 0x00.
- Access detection: edge = bus_cs_i & ~cs_q. The edge is ignored unless the FSM is in IDLE, so an access is never queued.
- FSM states: IDLE, RD_STB, RD_WAIT, ACK.
  - Any access except a RXDATA read goes IDLE -> ACK -> IDLE.
  - RXDATA read with p_empty_i = 0: IDLE -> RD_STB (n_rd_o = 0 for one cycle) -> RD_WAIT (RD_LAT cycles; data_i is captured in the last one) -> ACK -> IDLE.
  - RXDATA read with p_empty_i = 1: no strobe, rx_udr set, rdata = 0x00, IDLE -> ACK.
- TXDATA write with p_full_i = 0: data_o = wdata and n_we_o = 0 for exactly one cycle. With p_full_i = 1: no strobe, tx_ovr set.
- A STATUS read returns the sticky flags and clears them in the same ACK cycle.
- An APPLY write with AUTO_APPLY pending produces a single pulse, not two.

## Timing
- Reset values: CtrlRegN_o = CTRLN_RST, p_We_o = 0, n_we_o = 1, n_rd_o = 1, data_o = 0, bus_ack_o = 0, bus_rdata_o = 0, stickies = 0, FSM = IDLE.
- AUTO_APPLY = 1: p_We_o = 1 in the first clock cycle after rst deasserts, for one cycle.
- Edge sampled in cycle N:
  - Register write: the register updates and bus_ack_o = 1 in N+1.
  - Strobes (n_we_o, p_We_o): active in N+1, concurrent with ack.
  - Non-FIFO read: ack and data in N+1. Status bits are those sampled in N.
  - RXDATA read: n_rd_o = 0 in N+1; data_i captured in N+1+RD_LAT; ack in N+2+RD_LAT.
- Every output strobe is exactly one cycle wide. Consecutive strobes are at least two cycles apart.
- rst asserted mid-access: all outputs return to reset values asynchronously. The in-flight access is dropped and never acked. Any strobe in progress is cut short.
- bus_cs_i still high at reset release: cs_q resets to 0, so this counts as an edge. The first sampled edge after reset is therefore a valid access.

## Structure
- Shared package uart_bus_pkg holds:
  - address constants ADDR_CTRL1..ADDR_PARERR
  - STATUS bit indices
  - the FSM state enum
- No sub-module: a single flat block with a 2-bit state register, an RD_LAT counter (2 bits) and the sticky flags.

## Test plan
- Reset with defaults 0x81/0x23/0x45 and AUTO_APPLY = 1 -> CtrlReg outputs = 0x81/0x23/0x45, one p_We_o pulse in the first cycle after release.
- Write CTRL2 = 0x9C, then write APPLY -> CtrlReg2_o = 0x9C from N+1; p_We_o high for exactly one cycle at the APPLY ack.
- Write TXDATA 0x5A with p_full_i = 0 -> data_o = 0x5A and a one-cycle n_we_o low at N+1. Repeat with p_full_i = 1 -> no strobe; a STATUS read returns 0x06; a second STATUS read returns 0x02.
- RD_LAT = 2, FIFO model returns 0xA7 two cycles after the strobe -> n_rd_o low at N+1, ack with rdata = 0xA7 at N+4.
- RXDATA read with p_empty_i = 1 -> no n_rd_o strobe, rdata = 0x00 acked at N+1; STATUS bit3 = 1.
- Assert rst during RD_WAIT -> no ack, n_rd_o = 1. After release, a PARERR read with ParityErrorNum_i = 0x11 returns 0x11 at N+1.
